// File: rtl/ex_stage.sv
// Execute stage: ALU, HI/LO register file, single-cycle signed MULT and
// a 32-step restoring signed DIV that stalls the upstream pipeline.
module ex_stage (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] ex_num1,
  input  logic [31:0] ex_num2,
  input  logic [3:0]  ex_aluOp,
  input  logic        ex_regWriteEn,
  input  logic [4:0]  ex_regWriteAddr,
  input  logic [31:0] ex_linkAddr,
  input  logic        ex_memWriteEn,
  input  logic [2:0]  ex_memOp,
  input  logic [31:0] ex_memAddr,
  output logic [31:0] exo_result,
  output logic        exo_regWriteEn,
  output logic [4:0]  exo_regWriteAddr,
  output logic        exo_memWriteEn,
  output logic [2:0]  exo_memOp,
  output logic [31:0] exo_memAddr,
  output logic        ex_stop_request
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 5;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_NOR  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_LINK = 4'd11;
  localparam logic [3:0] OP_MULT = 4'd12;
  localparam logic [3:0] OP_DIV  = 4'd13;
  localparam logic [3:0] OP_MFHI = 4'd14;
  localparam logic [3:0] OP_MFLO = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]     rem_q, rem_d;
  logic [XLEN-1:0]     quo_q, quo_d;
  logic [XLEN-1:0]     dvsr_q, dvsr_d;
  logic                neg_num_q, neg_num_d;
  logic                neg_den_q, neg_den_d;
  logic [XLEN-1:0]     hi_q, hi_d;
  logic [XLEN-1:0]     lo_q, lo_d;

  logic                div_start;
  logic [XLEN:0]       shifted;
  logic [XLEN:0]       diff;
  logic                trial_ok;
  logic [XLEN-1:0]     abs_num1;
  logic [XLEN-1:0]     abs_num2;
  logic signed [2*XLEN-1:0] prod;
  logic [4:0]          shamt;

  assign div_start = (state_q == S_IDLE) && (ex_aluOp == OP_DIV);
  assign ex_stop_request = rstn & (div_start | (state_q == S_BUSY));

  assign abs_num1 = ex_num1[XLEN-1] ? (~ex_num1 + 32'd1) : ex_num1;
  assign abs_num2 = ex_num2[XLEN-1] ? (~ex_num2 + 32'd1) : ex_num2;
  assign prod = $signed({{XLEN{ex_num1[XLEN-1]}}, ex_num1})
              * $signed({{XLEN{ex_num2[XLEN-1]}}, ex_num2});
  assign shamt = ex_num1[4:0];

  // One restoring step: shift next dividend bit into the partial remainder.
  assign shifted  = {rem_q, quo_q[XLEN-1]};
  assign diff     = shifted - {1'b0, dvsr_q};
  assign trial_ok = ~diff[XLEN];

  // ALU result mux
  always_comb begin
    exo_result = '0;
    case (ex_aluOp)
      OP_NOP:  exo_result = '0;
      OP_ADD:  exo_result = ex_num1 + ex_num2;
      OP_SUB:  exo_result = ex_num1 - ex_num2;
      OP_AND:  exo_result = ex_num1 & ex_num2;
      OP_OR:   exo_result = ex_num1 | ex_num2;
      OP_XOR:  exo_result = ex_num1 ^ ex_num2;
      OP_NOR:  exo_result = ~(ex_num1 | ex_num2);
      OP_SLT:  exo_result = {31'd0, ($signed(ex_num1) < $signed(ex_num2))};
      OP_SLL:  exo_result = ex_num2 << shamt;
      OP_SRL:  exo_result = ex_num2 >> shamt;
      OP_SRA:  exo_result = $unsigned($signed(ex_num2) >>> shamt);
      OP_LINK: exo_result = ex_linkAddr;
      OP_MULT: exo_result = '0;
      OP_DIV:  exo_result = '0;
      OP_MFHI: exo_result = hi_q;
      OP_MFLO: exo_result = lo_q;
      default: exo_result = '0;
    endcase
  end

  assign exo_regWriteEn   = ex_regWriteEn & ~ex_stop_request;
  assign exo_memWriteEn   = ex_memWriteEn & ~ex_stop_request;
  assign exo_regWriteAddr = ex_regWriteAddr;
  assign exo_memOp        = ex_memOp;
  assign exo_memAddr      = ex_memAddr;

  // Divider sequencing and HI/LO update
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    neg_num_d = neg_num_q;
    neg_den_d = neg_den_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      S_IDLE: begin
        if (div_start) begin
          neg_num_d = ex_num1[XLEN-1];
          neg_den_d = ex_num2[XLEN-1];
          quo_d     = abs_num1;
          dvsr_d    = abs_num2;
          rem_d     = '0;
          cnt_d     = '0;
          state_d   = S_BUSY;
        end else if (ex_aluOp == OP_MULT) begin
          hi_d = prod[2*XLEN-1:XLEN];
          lo_d = prod[XLEN-1:0];
        end
      end
      S_BUSY: begin
        rem_d = trial_ok ? diff[XLEN-1:0] : shifted[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], trial_ok};
        if (cnt_q == 5'd31) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_DONE: begin
        // With a zero divisor the remainder is |num1|, so the sign fix on HI
        // reproduces the raw dividend; only LO needs the special case.
        if (dvsr_q == '0) begin
          lo_d = '1;
        end else begin
          lo_d = (neg_num_q ^ neg_den_q) ? (~quo_q + 32'd1) : quo_q;
        end
        hi_d    = neg_num_q ? (~rem_q + 32'd1) : rem_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      neg_num_q <= 1'b0;
      neg_den_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      neg_num_q <= neg_num_d;
      neg_den_q <= neg_den_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage pipelined MIPS core. It sits directly downstream of the ID/EX pipeline register and consumes its `ex_*` outputs. It computes the ALU result and owns the HI/LO registers, including a single-cycle signed MULT and a multi-cycle signed DIV. It drives the EX/MEM register inputs and raises a pipeline stall while a division is in progress.

## Interface
- No parameters.
- `clk` in 1: clock; all state updates on rising edge.
- `rstn` in 1: reset; one clock; reset is synchronous and active-low.
- `ex_num1`, `ex_num2` in 32: operands from ID/EX.
- `ex_aluOp` in 4: operation code (encoding under Operation).
- `ex_regWriteEn` in 1, `ex_regWriteAddr` in 5: register writeback request.
- `ex_linkAddr` in 32: return address for link instructions.
- `ex_memWriteEn` in 1, `ex_memOp` in 3, `ex_memAddr` in 32: memory controls and store data; passed through unchanged.
- `exo_result` out 32: ALU result, also the load/store address.
- `exo_regWriteEn` out 1, `exo_regWriteAddr` out 5: writeback request to EX/MEM.
- `exo_memWriteEn` out 1, `exo_memOp` out 3, `exo_memAddr` out 32: pass-through to EX/MEM.
- `ex_stop_request` out 1: stall request. While it is high, PC, IF/ID and ID/EX hold their contents.

## Operation
- ALU opcodes (combinational; all results 32-bit; no overflow trap):
  - 0 NOP: result 0.
  - 1 ADD / 2 SUB: wrap-around arithmetic.
  - 3 AND, 4 OR, 5 XOR, 6 NOR: bitwise.
  - 7 SLT: signed compare; result 1 or 0.
  - 8 SLL / 9 SRL / 10 SRA: shift `num2` by `num1[4:0]`.
  - 11 LINK: result = `ex_linkAddr`.
- HI/LO opcodes:
  - 12 MULT: signed 32x32 multiply to a 64-bit product; HI = product[63:32], LO = product[31:0]; written at the end of the cycle. Result 0.
  - 13 DIV: signed divide, multi-cycle. Result 0.
  - 14 MFHI: result = HI register.
  - 15 MFLO: result = LO register.
- Pass-through outputs: `exo_memWriteEn`, `exo_memOp`, `exo_memAddr` and `exo_regWriteAddr` equal their inputs.
- Gated outputs: `exo_regWriteEn = ex_regWriteEn & ~ex_stop_request`. `exo_memWriteEn` is gated the same way, so EX/MEM receives a bubble on every stall cycle.
- Divider FSM states: IDLE, BUSY, DONE.
  - IDLE: if `aluOp==13`, latch |num1| and |num2| and both sign bits, clear the 5-bit counter, go to BUSY.
  - BUSY: one restoring shift-subtract step per cycle on the 32-bit remainder and quotient. When counter==31, go to DONE; otherwise increment the counter.
  - DONE: write HI/LO, go to IDLE. The DIV instruction is still present in EX during DONE and is ignored; ID/EX advances at this edge.
- Division results:
  - LO = quotient, negated if the operand signs differ.
  - HI = remainder, negated if the dividend was negative.
  - Both truncate toward zero.
- Divide by zero: timing is unchanged; LO = 32'hFFFFFFFF and HI = `ex_num1` as latched, with no sign fix.
- `ex_stop_request = rstn & ((state==IDLE & aluOp==13) | state==BUSY)`. This is combinational.

## Timing
- Reset (edge with `rstn`=0):
  - HI = LO = 0, FSM = IDLE, counter = 0.
  - `ex_stop_request` is 0 while `rstn` is low.
  - All other outputs are combinational from their inputs.
- Reset during BUSY aborts the division: HI/LO become 0 and stop is low from the reset cycle onward.
- Latency: ALU ops and MULT take 1 cycle. MFHI/MFLO read the register value after the previous edge, so MULT immediately followed by MFLO returns the new LO.
- DIV timing:
  - Occupies EX for 34 cycles (1 IDLE + 32 BUSY + 1 DONE).
  - `ex_stop_request` is high for exactly 33 consecutive cycles.
  - HI/LO update at the DONE edge, so MFHI in the next cycle sees the quotient and remainder.
- A DIV immediately following a completed DIV starts a fresh division in IDLE. Back-to-back divisions therefore take 34 cycles each.
- MFHI/MFLO never enter EX during BUSY, because the upstream stages are held.

## Test plan
- ADD 0x7FFFFFFF + 1 gives result 0x80000000. SLT -1 vs 1 gives 1. SRA by `num1`=4 on `num2`=0x80000000 gives 0xF8000000. All settle in the same cycle with stop = 0.
- MULT -3 × 5, then MFHI, then MFLO: results 0xFFFFFFFF and 0xFFFFFFF1.
- DIV -7 / 2: stop high for 33 cycles, `exo_regWriteEn` held at 0 throughout. Then MFLO gives 0xFFFFFFFD and MFHI gives 0xFFFFFFFF.
- DIV 5 / 0: 33 stall cycles, then LO = 0xFFFFFFFF and HI = 5.
- Two back-to-back DIVs (100/7, then 9/3): stop high for 33 cycles, low for one cycle, then high for 33 cycles. Final LO = 3, HI = 0.
- `rstn` pulled low at BUSY cycle 10: stop drops that cycle; HI = LO = 0, FSM = IDLE. A following ADD completes normally.
